cmd_queue: RTL and testbench

CMD_QUEUE -- requirements
Module: cmd_queue

---
 rtl/cmd_queue_pkg.sv | 30 +++
 rtl/cmd_fifo_mem.sv | 41 ++++
 rtl/cmd_queue.sv | 164 ++++++++++++++++
 tb/tb_cmd_queue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_queue_pkg
//  Description : Shared command-word definitions for the command queue and
//                the dispatcher: opcode field position, legal opcodes and
//                the queue state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cmd_queue_pkg;

  localparam int CMD_W        = 64;
  localparam int OP_MSB       = 63;
  localparam int OP_LSB       = 56;
  localparam int CORE_SEL_BIT = 55;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_NTT  = 8'h01;
  localparam logic [7:0] OP_DMA  = 8'h02;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } q_state_e;

  function automatic logic op_is_legal(input logic [7:0] op);
    return (op == OP_HALT) || (op == OP_NTT) || (op == OP_DMA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_fifo_mem
//  Description : DEPTH x 64 command storage, one synchronous write port and
//                one asynchronous read port (show-ahead head entry).
//  Ports       : clk      - write clock
//                wr_en    - write strobe
//                wr_addr  - write address (AW bits)
//                wr_data  - command word to store
//                rd_addr  - read address (AW bits)
//                rd_data  - command word at rd_addr, combinational
//  Revision    : 1.0  initial release
// ============================================================================
module cmd_fifo_mem
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CMD_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [CMD_W-1:0] rd_data
);

  // Storage is intentionally not reset: occupancy lives in the controller,
  // so stale contents are never presented as valid.
  logic [CMD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_queue
//  Description : Host-to-dispatcher command FIFO with opcode filtering and a
//                RUN/HALTED flow-control FSM. A popped HALT opcode stops the
//                queue offering commands until resume or flush.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                host_valid/ready/data- host push handshake
//                cmd_valid/ready/data - dispatcher pop handshake (show-ahead)
//                flush                - discard contents, back to RUN
//                resume               - leave HALTED
//                level                - occupancy 0..DEPTH
//                halted_q             - high while HALTED
//                illegal_err          - sticky, illegal opcode rejected
//                issued_cnt/stall_cnt - only with CMD_QUEUE_STATS_EN
//  Options     : CMD_QUEUE_STATS_EN adds saturating pop / stall counters.
//  Revision    : 1.0  initial release
// ============================================================================
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_valid,
  input  logic [63:0]   host_data,
  output logic          host_ready,
  output logic          cmd_valid,
  output logic [63:0]   cmd_data,
  input  logic          cmd_ready,
  input  logic          flush,
  input  logic          resume,
  output logic [AW:0]   level,
  output logic          halted_q,
  output logic          illegal_err
`ifdef CMD_QUEUE_STATS_EN
  ,
  output logic [31:0]   issued_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  q_state_e      state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          illegal_q, illegal_d;

  logic full;
  logic push_acc;
  logic op_ok;
  logic store;
  logic pop;

  assign full       = (level_q == (AW+1)'(DEPTH));
  // Blocking push during flush means a flush-cycle word is simply dropped.
  assign host_ready = !full && !flush;
  assign push_acc   = host_valid && host_ready;
  assign op_ok      = op_is_legal(host_data[OP_MSB:OP_LSB]);
  assign store      = push_acc && op_ok;
  assign cmd_valid  = (level_q != '0) && (state_q == ST_RUN);
  assign pop        = cmd_valid && cmd_ready && !flush;

  assign level       = level_q;
  assign halted_q    = (state_q == ST_HALTED);
  assign illegal_err = illegal_q;

  cmd_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (store),
    .wr_addr (wr_ptr_q),
    .wr_data (host_data),
    .rd_addr (rd_ptr_q),
    .rd_data (cmd_data)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    illegal_d = illegal_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      illegal_d = 1'b0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({store, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
      if (push_acc && !op_ok) illegal_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    if (pop && (cmd_data[OP_MSB:OP_LSB] == OP_HALT)) state_d = ST_HALTED;
        ST_HALTED: if (resume) state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef CMD_QUEUE_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (flush) begin
      issued_d = '0;
      stall_d  = '0;
    end else begin
      if (pop && (issued_q != 32'hFFFF_FFFF)) issued_d = issued_q + 32'd1;
      if (cmd_valid && !cmd_ready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign issued_cnt = issued_q;
  assign stall_cnt  = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_queue
//  Description : Directed self-checking bench for cmd_queue. A queue-based
//                reference model tracks expected outputs every cycle; literal
//                expectations pin key scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmd_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_valid = 1'b0;
  logic [63:0]   host_data = '0;
  logic          host_ready;
  logic          cmd_valid;
  logic [63:0]   cmd_data;
  logic          cmd_ready = 1'b0;
  logic          flush = 1'b0;
  logic          resume = 1'b0;
  logic [AW:0]   level;
  logic          halted_q;
  logic          illegal_err;
`ifdef CMD_QUEUE_STATS_EN
  logic [31:0]   issued_cnt;
  logic [31:0]   stall_cnt;
`endif

  cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_valid  (host_valid),
    .host_data   (host_data),
    .host_ready  (host_ready),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .flush       (flush),
    .resume      (resume),
    .level       (level),
    .halted_q    (halted_q),
    .illegal_err (illegal_err)
`ifdef CMD_QUEUE_STATS_EN
    ,
    .issued_cnt  (issued_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mq[$];
  bit          m_halted  = 1'b0;
  bit          m_illegal = 1'b0;
  logic [31:0] m_issued  = '0;
  logic [31:0] m_stall   = '0;
  int          m_sz;
  bit          m_offer;
  logic [63:0] m_word;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || flush) begin
      mq.delete();
      m_halted  = 1'b0;
      m_illegal = 1'b0;
      m_issued  = '0;
      m_stall   = '0;
    end else begin
      m_sz    = mq.size();
      m_offer = (m_sz != 0) && !m_halted;
      if (m_offer && !cmd_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (m_offer && cmd_ready) begin
        m_word = mq.pop_front();
        if (m_word[63:56] == 8'h00) m_halted = 1'b1;
        if (m_issued != 32'hFFFF_FFFF) m_issued = m_issued + 1;
      end else if (m_halted && resume) begin
        m_halted = 1'b0;
      end
      if (host_valid && m_sz < DEPTH) begin
        if (host_data[63:56] <= 8'h02) mq.push_back(host_data);
        else m_illegal = 1'b1;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit e_valid;
  initial forever begin
    @(negedge clk);
    e_valid = (mq.size() != 0) && !m_halted;
    check("host_ready", 64'(host_ready), 64'((mq.size() < DEPTH) && !flush));
    check("cmd_valid", 64'(cmd_valid), 64'(e_valid));
    check("level", 64'(level), 64'(mq.size()));
    check("halted_q", 64'(halted_q), 64'(m_halted));
    check("illegal_err", 64'(illegal_err), 64'(m_illegal));
    if (e_valid) check("cmd_data", cmd_data, mq[0]);
`ifdef CMD_QUEUE_STATS_EN
    check("issued_cnt", 64'(issued_cnt), 64'(m_issued));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    host_valid = 1'b1;
    host_data  = w;
    tick();
    host_valid = 1'b0;
  endtask

  logic [63:0] w_ntt  = 64'h0100_0000_0000_0001;
  logic [63:0] w_n3   = 64'h0100_0000_0000_0A01;
  logic [63:0] w_halt = 64'h0000_0000_0000_0B00;
  logic [63:0] w_dma  = 64'h0200_0000_0000_0C02;
  logic [63:0] w_n4   = 64'h0180_0000_0000_0D01;
  logic [63:0] w_bad  = 64'h7F00_0000_0000_0001;
  logic [63:0] w;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_host_ready", 64'(host_ready), 64'd1);
    check("rst_halted", 64'(halted_q), 64'd0);
    check("rst_illegal", 64'(illegal_err), 64'd0);
    tick();

    // single word latency
    cmd_ready = 1'b1;
    host_valid = 1'b1;
    host_data = w_ntt;
    check("t1_pre_valid", 64'(cmd_valid), 64'd0);
    tick();
    host_valid = 1'b0;
    check("t1_valid", 64'(cmd_valid), 64'd1);
    check("t1_data", cmd_data, w_ntt);
    check("t1_level", 64'(level), 64'd1);
    tick();
    check("t1_level_after", 64'(level), 64'd0);
    check("t1_valid_after", 64'(cmd_valid), 64'd0);
`ifdef CMD_QUEUE_STATS_EN
    check("t1_issued", 64'(issued_cnt), 64'd1);
`endif

    // fill to full, overflow attempt, drain in order
    cmd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w = {8'h01, 56'(i) + 56'h100};
      push_word(w);
    end
    check("t2_level_full", 64'(level), 64'd16);
    check("t2_ready_full", 64'(host_ready), 64'd0);
    push_word(64'h0100_0000_0000_0FFF);
    check("t2_level_still", 64'(level), 64'd16);
    check("t2_head", cmd_data, 64'h0100_0000_0000_0100);
    cmd_ready = 1'b1;
    repeat (DEPTH) tick();
    check("t2_drained", 64'(level), 64'd0);

    // HALT handling and resume
    cmd_ready = 1'b0;
    push_word(w_n3);
    push_word(w_halt);
    push_word(w_dma);
    check("t3_level3", 64'(level), 64'd3);
    cmd_ready = 1'b1;
    tick();
    check("t3_head_halt", cmd_data, w_halt);
    check("t3_level2", 64'(level), 64'd2);
    tick();
    check("t3_halted", 64'(halted_q), 64'd1);
    check("t3_level1", 64'(level), 64'd1);
    check("t3_no_offer", 64'(cmd_valid), 64'd0);
    push_word(w_n4);
    check("t3_push_halted", 64'(level), 64'd2);
    check("t3_still_halted", 64'(halted_q), 64'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("t3_resumed", 64'(halted_q), 64'd0);
    check("t3_dma_head", cmd_data, w_dma);
    check("t3_dma_valid", 64'(cmd_valid), 64'd1);
    tick();
    check("t3_n4_head", cmd_data, w_n4);
    tick();
    check("t3_empty", 64'(level), 64'd0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("t3_resume_in_run", 64'(halted_q), 64'd0);

    // illegal opcode, then flush
    cmd_ready = 1'b0;
    host_valid = 1'b1;
    host_data = w_bad;
    check("t4_ready_bad", 64'(host_ready), 64'd1);
    tick();
    host_valid = 1'b0;
    check("t4_level", 64'(level), 64'd0);
    check("t4_illegal", 64'(illegal_err), 64'd1);
    tick();
    check("t4_sticky", 64'(illegal_err), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_flush_illegal", 64'(illegal_err), 64'd0);
    check("t4_flush_level", 64'(level), 64'd0);

    // flush + push + pop on a full queue
    for (int i = 0; i < DEPTH; i++) begin
      w = {8'h02, 56'(i) + 56'h200};
      push_word(w);
    end
    flush = 1'b1;
    host_valid = 1'b1;
    host_data = w_ntt;
    cmd_ready = 1'b1;
    check("t5_ready_flush", 64'(host_ready), 64'd0);
    tick();
    flush = 1'b0;
    host_valid = 1'b0;
    check("t5_level", 64'(level), 64'd0);
    check("t5_valid", 64'(cmd_valid), 64'd0);
    check("t5_halted", 64'(halted_q), 64'd0);
`ifdef CMD_QUEUE_STATS_EN
    check("t5_issued", 64'(issued_cnt), 64'd0);
`endif
    push_word(w_halt);
    push_word(w_n3);
    check("t5_halt_again", 64'(halted_q), 64'd1);
    check("t5_level1", 64'(level), 64'd1);
    flush = 1'b1;
    resume = 1'b1;
    tick();
    flush = 1'b0;
    resume = 1'b0;
    check("t5_flush_halt", 64'(halted_q), 64'd0);
    check("t5_flush_lvl", 64'(level), 64'd0);

    // asynchronous reset mid-drain
    cmd_ready = 1'b0;
    push_word(w_bad);
    for (int i = 0; i < 5; i++) begin
      w = {8'h01, 56'(i) + 56'h300};
      push_word(w);
    end
    check("t6_level5", 64'(level), 64'd5);
    cmd_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_level", 64'(level), 64'd0);
    check("t6_rst_valid", 64'(cmd_valid), 64'd0);
    check("t6_rst_illegal", 64'(illegal_err), 64'd0);
    check("t6_rst_halted", 64'(halted_q), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check("t6_rel_level", 64'(level), 64'd0);
    check("t6_rel_valid", 64'(cmd_valid), 64'd0);
    check("t6_rel_ready", 64'(host_ready), 64'd1);
`ifdef CMD_QUEUE_STATS_EN
    check("t6_rel_issued", 64'(issued_cnt), 64'd0);
    check("t6_rel_stall", 64'(stall_cnt), 64'd0);
`endif
    cmd_ready = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
